// File: rtl/seg_bcd_writer.sv
// seg_bcd_writer: binary-to-BCD double-dabble converter that writes the result to a 7-seg PIO over Avalon-MM. Ports: clk/reset, req_valid/req_ready/req_value, busy, ovf, seg_address/seg_chipselect/seg_write_n/seg_writedata. Optional SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits with 4'hF.
module seg_bcd_writer #(
  parameter int BIN_W = 20,
  parameter int DIGITS = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [BIN_W-1:0] req_value,
  output logic             busy,
  output logic             ovf,
  output logic [1:0]       seg_address,
  output logic             seg_chipselect,
  output logic             seg_write_n,
  output logic [31:0]      seg_writedata
);
  localparam int BW = 4*DIGITS;
  localparam logic [31:0] MAXV = 32'(10**DIGITS - 1);
  if (BIN_W < 4 || BIN_W > 24 || DIGITS < 1 || DIGITS > 8) begin : g_bad_params
    $error("seg_bcd_writer: illegal BIN_W or DIGITS");
  end
  typedef enum logic [1:0] {IDLE, CONVERT, WRITE} state_t;
  state_t state, nxt;
  logic [BIN_W-1:0] bin;
  logic [BW-1:0] bcd, adj, fmt;
  logic [4:0] cnt;
  logic ovf_p, sat, accept;
  logic [31:0] wd_q;
  assign sat = 32'(req_value) > MAXV;
  assign req_ready = state == IDLE && !reset;
  assign accept = req_valid && req_ready;
  // strobes are gated by reset so no write escapes in the cycle reset is sampled
  assign seg_chipselect = state == WRITE && !reset;
  assign seg_write_n = !seg_chipselect;
  assign seg_address = 2'd0;
  assign seg_writedata = seg_chipselect ? 32'(fmt) : wd_q;
  assign busy = state != IDLE && !reset;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
  end
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic lead;
  always_comb begin
    fmt = bcd;
    lead = 1'b1;
    for (int i = DIGITS-1; i > 0; i--) begin
      lead = lead && bcd[4*i+:4] == 4'd0;
      fmt[4*i+:4] = lead ? 4'hF : bcd[4*i+:4];
    end
  end
`else
  assign fmt = bcd;
`endif
  always_comb begin
    nxt = state == IDLE    ? (accept ? CONVERT : IDLE) :
          state == CONVERT ? (cnt == 5'd1 ? WRITE : CONVERT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      ovf_p <= 1'b0;
      ovf <= 1'b0;
      wd_q <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        bin <= sat ? BIN_W'(MAXV) : req_value;
        ovf_p <= sat;
        bcd <= '0;
        cnt <= 5'(BIN_W);
      end else if (state == CONVERT) begin
        {bcd, bin} <= {adj, bin} << 1;
        cnt <= cnt - 5'd1;
      end else if (state == WRITE) begin
        wd_q <= 32'(fmt);
        ovf <= ovf_p;
      end
    end
  end
endmodule

// File: tb/tb_seg_bcd_writer.sv
// tb_seg_bcd_writer: directed plus random checks of seg_bcd_writer against a decimal-digit reference model.
module tb_seg_bcd_writer;
  logic clk, reset, req_valid, req_ready, busy, ovf, seg_chipselect, seg_write_n;
  logic [19:0] req_value;
  logic [1:0] seg_address;
  logic [31:0] seg_writedata;
  int checks = 0, errors = 0, cyc = 0, rl = 0;
  int acc_q[$], rq[$], wq_c[$];
  logic [31:0] wq_d[$];
  logic [1:0] wq_a[$];
  seg_bcd_writer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_value(req_value), .busy(busy), .ovf(ovf), .seg_address(seg_address),
    .seg_chipselect(seg_chipselect), .seg_write_n(seg_write_n), .seg_writedata(seg_writedata)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && !req_ready) rl <= rl + 1;
    if (req_valid && req_ready) begin
      acc_q.push_back(cyc);
      rq.push_back(rl);
    end
    if (seg_chipselect && !seg_write_n) begin
      wq_c.push_back(cyc);
      wq_d.push_back(seg_writedata);
      wq_a.push_back(seg_address);
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  function automatic logic [31:0] model(input int v);
    int s;
    logic [31:0] r;
    s = v > 999999 ? 999999 : v;
    r = '0;
    for (int i = 0; i < 6; i++) r[4*i+:4] = 4'((s / (10**i)) % 10);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    for (int i = 5; i > 0; i--) begin
      if (r[4*i+:4] != 4'd0) break;
      r[4*i+:4] = 4'hF;
    end
`endif
    return r;
  endfunction
  task automatic do_req(input int v);
    int a0, w0;
    a0 = acc_q.size();
    w0 = wq_d.size();
    @(negedge clk);
    req_valid = 1;
    req_value = 20'(v);
    for (int k = 0; k < 5 && acc_q.size() == a0; k++) @(negedge clk);
    chk("accept", acc_q.size(), a0 + 1);
    req_valid = 0;
    req_value = 20'($urandom);
    for (int k = 0; k < 40 && wq_d.size() == w0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("write_count", wq_d.size(), w0 + 1);
    if (wq_d.size() > w0 && acc_q.size() > a0) begin
      chk("latency", wq_c[w0] - acc_q[a0], 21);
      chk("writedata", wq_d[w0], model(v));
      chk("address", 32'(wq_a[w0]), 0);
      chk("ready_low", rl - rq[a0], 21);
    end
    chk("ovf", 32'(ovf), 32'(v > 999999));
    chk("idle_ready", 32'(req_ready), 1);
  endtask
  initial begin
    int a0, w0;
    reset = 1;
    req_valid = 0;
    req_value = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_cs", 32'(seg_chipselect), 0);
    chk("rst_wn", 32'(seg_write_n), 1);
    chk("rst_busy", 32'(busy), 0);
    reset = 0;
    @(negedge clk);
    chk("rst_wd", seg_writedata, 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_addr", 32'(seg_address), 0);
    chk("post_rst_ready", 32'(req_ready), 1);
    do_req(123456);
    do_req(0);
    do_req(42);
    do_req(1048575);
    do_req(7);
    a0 = acc_q.size();
    w0 = wq_d.size();
    @(negedge clk);
    req_valid = 1;
    req_value = 1;
    for (int n = 2; n <= 4; n++) begin
      for (int k = 0; k < 30 && acc_q.size() < a0 + n - 1; k++) @(negedge clk);
      req_value = 20'(n);
    end
    req_valid = 0;
    repeat (30) @(negedge clk);
    chk("held_accepts", acc_q.size(), a0 + 3);
    chk("held_writes", wq_d.size(), w0 + 3);
    if (wq_d.size() >= w0 + 3 && acc_q.size() > a0)
      for (int i = 0; i < 3; i++) begin
        chk("held_cycle", wq_c[w0+i] - acc_q[a0], 21 + 22*i);
        chk("held_data", wq_d[w0+i], model(i + 1));
      end
    a0 = acc_q.size();
    w0 = wq_d.size();
    @(negedge clk);
    req_valid = 1;
    req_value = 20'd555555;
    for (int k = 0; k < 5 && acc_q.size() == a0; k++) @(negedge clk);
    chk("mid_accept", acc_q.size(), a0 + 1);
    req_valid = 0;
    repeat (10) @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    reset = 1;
    #1;
    chk("mid_rst_cs", 32'(seg_chipselect), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("mid_busy_after", 32'(busy), 0);
    chk("mid_ready_after", 32'(req_ready), 1);
    repeat (30) @(negedge clk);
    chk("mid_no_write", wq_d.size(), w0);
    do_req(999999);
    for (int i = 0; i < 8; i++) do_req(int'($urandom_range(0, 1048575)));
    do_req(1000000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_bcd_writer.md
Name: seg_bcd_writer

Overview:
- Avalon-MM write master that feeds the 24-bit seven-segment PIO slave (6 BCD nibbles, digit 0 in bits [3:0]).
- Accepts a binary value on a valid/ready port and converts it to BCD with a sequential shift-add-3 (double-dabble) engine.
- Issues one single-cycle write to PIO address 0.
- Sits between the CPU or sensor-side logic that produces values and the SEG PIO. Software no longer does binary-to-BCD conversion.

Parameters:
- BIN_W, 20: width of the binary input value. Legal range 4..24.
- DIGITS, 6: number of BCD digits. Output payload is 4*DIGITS bits, which must be ≤ 32.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  block can accept a request.
- req_value  in  BIN_W  unsigned binary value to display.
- busy  out  1  high from the accept edge through the write cycle.
- ovf  out  1  last written value was saturated.
- seg_address  out  2  PIO word address. Always 0.
- seg_chipselect  out  1  PIO chipselect.
- seg_write_n  out  1  PIO write strobe, active-low.
- seg_writedata  out  32  PIO write data.

Behaviour:
- One clock. Reset is synchronous and active-high, on ports clk and reset.
- Reset values: state IDLE, seg_chipselect 0, seg_write_n 1, seg_address 0, seg_writedata 0, busy 0, ovf 0. While reset is high, req_ready is 0.
- Handshake: a request is accepted on a rising edge where req_valid=1 and req_ready=1.
  - req_ready = 1 only in IDLE, and only while reset is low.
  - req_value is captured at the accept edge. The source may change it afterwards.
- Saturation check at accept: if req_value > 10^DIGITS−1, the converted value is replaced by 10^DIGITS−1 (all nines) and ovf_pending is set. Otherwise ovf_pending is cleared.
- FSM:
  - IDLE → CONVERT on accept. Load the shift register with the captured (or saturated) value, clear the BCD accumulator, set counter = BIN_W.
  - CONVERT: each cycle, do the following, then decrement the counter.
    - Add 3 to every BCD nibble that is ≥ 5.
    - Shift {bcd, bin} left by 1.
    - When the counter reaches 1 and that cycle's shift completes, go to WRITE.
  - WRITE, exactly one cycle:
    - seg_chipselect=1, seg_write_n=0, seg_address=0.
    - seg_writedata = {zero-extended, bcd[4*DIGITS−1:0]}.
    - ovf <= ovf_pending. Then go to IDLE.
- The BCD accumulator is 4*DIGITS bits wide. Saturation guarantees no nibble overflow.
- Latency: the write strobe is asserted in cycle BIN_W+1 after the accept edge (cycle 21 for the defaults).
- Throughput: the next accept is possible one cycle after WRITE. req_ready is low for BIN_W+1 cycles per request.
- busy = (state != IDLE).
- seg_writedata holds its last value outside WRITE. seg_chipselect and seg_write_n are idle-deasserted in every non-WRITE cycle.
- The slave has no waitrequest, so no stall handling is needed. The write completes in one cycle.
- Reset mid-operation (CONVERT or WRITE): return to IDLE next edge. No write is issued or completed after reset asserts. All outputs take their reset values.
- req_valid held high continuously: the next request is accepted on the first IDLE edge. No requests are dropped or duplicated.
- BIN_W=0 or DIGITS outside 1..8 is illegal. The block emits an elaboration-time error.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: in WRITE, every nibble above the most-significant non-zero digit is replaced by 4'hF (blank code for the downstream decoder). Digit 0 is never blanked, so a value of 0 shows "0". This adds one combinational scan over the final BCD and no extra cycle.
- Undefined: leading zeros are written as 4'h0. Latency is identical in both builds.

Test Plan:
- Reset 3 cycles, then req_value=123456 held with valid → accept at edge 0. Required: req_ready low 21 cycles, exactly one write at cycle 21 with writedata=0x00123456, address 0, ovf=0.
- req_value=0 → writedata=0x00000000 without the macro, 0x00FFFFF0 with it. Then 42 → 0x00000042 without, 0x00FFFF42 with.
- req_value=1048575 (> 999999) → writedata=0x00999999, ovf=1 after the write. A following request of 7 → 0x00000007 (blanked build 0x00FFFFF7) and ovf returns to 0.
- req_valid held high with values 1, 2, 3 changed after each accept → three writes at cycles 21, 43, 65 with 0x1, 0x2, 0x3. No extra chipselect cycles.
- Assert reset at cycle 10 of CONVERT for 1 cycle → no write issued. busy=0 and req_ready=1 one cycle after reset deasserts. A new request of 999999 → 0x00999999, ovf=0.
